// File: rtl/bitstream_encoder.sv
// Variable-length entropy encoder: loads one 8x8 block of scan-ordered coefficients,
// emits prefix codes MSB-first through a 32-bit bit packer into 16-bit SRAM words.
module bitstream_encoder #(
    parameter logic [17:0] OUTPUT_OFFSET = 18'd76800
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        start,
    input  logic        quantization,
    input  logic [14:0] width,
    input  logic [15:0] height,
    input  logic        block_start,
    input  logic        flush,
    output logic [5:0]  coef_address,
    input  logic [8:0]  coef_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        busy,
    output logic        block_done,
    output logic        flush_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_LOAD,
        S_ENCODE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_reg;
    logic [1:0]  hdr_cnt_reg;
    logic [6:0]  ld_cnt_reg;
    logic [6:0]  pos_reg;
    logic [5:0]  last_nz_reg;
    logic        all_zero_reg;
    logic [31:0] acc_reg;
    logic [4:0]  count_reg;
    logic [17:0] next_addr_reg;
    logic        q_reg;
    logic [14:0] width_reg;
    logic [15:0] height_reg;

    logic [8:0]  coef_buf [64];
    logic [5:0]  ld_idx;

    logic [7:0]  win_zero;
    logic [3:0]  win_one;
    logic [3:0]  win_mone;
    logic [3:0]  zrun;
    logic [2:0]  orun;
    logic [2:0]  mrun;
    logic        zstop, ostop, mstop;

    logic [8:0]  v;
    logic        v_small;
    logic [10:0] code_val;
    logic [3:0]  code_len;
    logic [3:0]  step;
    logic        term;
    logic [6:0]  pos_next;
    logic        block_end;

    logic [5:0]  shift_amt;
    logic [31:0] appended;
    logic [4:0]  cnt_sum;

    assign busy   = (state_reg != S_IDLE);
    assign ld_idx = ld_cnt_reg[5:0] - 6'd1;

    // Load data lags coef_address by one cycle, so entry ld_cnt-1 lands on each load cycle.
    always_ff @(posedge CLOCK_50_I) begin
        if (state_reg == S_LOAD && ld_cnt_reg != 7'd0)
            coef_buf[ld_idx] <= coef_data;
    end

    // Window of the 8 entries at and after the current position; out-of-block entries never match.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_win
            logic [6:0] idx;
            assign idx          = pos_reg + 7'(gi);
            assign win_zero[gi] = ~idx[6] && (coef_buf[idx[5:0]] == 9'd0);
            if (gi < 4) begin : g_pm
                assign win_one[gi]  = ~idx[6] && (coef_buf[idx[5:0]] == 9'h001);
                assign win_mone[gi] = ~idx[6] && (coef_buf[idx[5:0]] == 9'h1FF);
            end
        end
    endgenerate

    always_comb begin
        zrun  = 4'd0;
        orun  = 3'd0;
        mrun  = 3'd0;
        zstop = 1'b0;
        ostop = 1'b0;
        mstop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!zstop && win_zero[k]) zrun = zrun + 4'd1;
            else zstop = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            if (!ostop && win_one[k]) orun = orun + 3'd1;
            else ostop = 1'b1;
            if (!mstop && win_mone[k]) mrun = mrun + 3'd1;
            else mstop = 1'b1;
        end
    end

    assign v       = coef_buf[pos_reg[5:0]];
    assign v_small = (v[8:3] == 6'h00) || (v[8:3] == 6'h3F);

    always_comb begin
        code_val = 11'd0;
        code_len = 4'd0;
        step     = 4'd0;
        term     = 1'b0;
        if (all_zero_reg || pos_reg > {1'b0, last_nz_reg}) begin
            code_val = 11'b111;
            code_len = 4'd3;
            term     = 1'b1;
        end else if (v == 9'd0) begin
            code_val = {5'd0, 3'b110, zrun[2:0]};
            code_len = 4'd6;
            step     = zrun;
        end else if (v == 9'h001) begin
            code_val = {6'd0, 3'b101, orun[1:0]};
            code_len = 4'd5;
            step     = {1'b0, orun};
        end else if (v == 9'h1FF) begin
            code_val = {6'd0, 3'b100, mrun[1:0]};
            code_len = 4'd5;
            step     = {1'b0, mrun};
        end else if (v_small) begin
            code_val = {5'd0, 2'b01, v[3:0]};
            code_len = 4'd6;
            step     = 4'd1;
        end else begin
            code_val = {2'b00, v};
            code_len = 4'd11;
            step     = 4'd1;
        end
    end

    assign pos_next  = pos_reg + {3'd0, step};
    assign block_end = term | pos_next[6];

    // Valid bits are left-aligned in the accumulator; new code goes just below them.
    assign shift_amt = 6'd32 - {1'b0, count_reg} - {2'd0, code_len};
    assign appended  = acc_reg | ({21'd0, code_val} << shift_amt);
    assign cnt_sum   = count_reg + {1'b0, code_len};

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            hdr_cnt_reg     <= 2'd0;
            ld_cnt_reg      <= 7'd0;
            pos_reg         <= 7'd0;
            last_nz_reg     <= 6'd0;
            all_zero_reg    <= 1'b1;
            acc_reg         <= 32'd0;
            count_reg       <= 5'd0;
            next_addr_reg   <= OUTPUT_OFFSET;
            q_reg           <= 1'b0;
            width_reg       <= 15'd0;
            height_reg      <= 16'd0;
            coef_address    <= 6'd0;
            SRAM_address    <= OUTPUT_OFFSET;
            SRAM_write_data <= 16'd0;
            SRAM_we_n       <= 1'b1;
            block_done      <= 1'b0;
            flush_done      <= 1'b0;
        end else begin
            SRAM_we_n  <= 1'b1;
            block_done <= 1'b0;
            flush_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        q_reg           <= quantization;
                        width_reg       <= width;
                        height_reg      <= height;
                        acc_reg         <= 32'd0;
                        count_reg       <= 5'd0;
                        SRAM_address    <= OUTPUT_OFFSET;
                        SRAM_write_data <= 16'hDEAD;
                        SRAM_we_n       <= 1'b0;
                        next_addr_reg   <= OUTPUT_OFFSET + 18'd1;
                        hdr_cnt_reg     <= 2'd1;
                        state_reg       <= S_HEADER;
                    end else if (block_start) begin
                        coef_address <= 6'd0;
                        ld_cnt_reg   <= 7'd0;
                        pos_reg      <= 7'd0;
                        last_nz_reg  <= 6'd0;
                        all_zero_reg <= 1'b1;
                        state_reg    <= S_LOAD;
                    end else if (flush) begin
                        state_reg <= S_FLUSH;
                    end
                end
                S_HEADER: begin
                    SRAM_address  <= next_addr_reg;
                    next_addr_reg <= next_addr_reg + 18'd1;
                    SRAM_we_n     <= 1'b0;
                    hdr_cnt_reg   <= hdr_cnt_reg + 2'd1;
                    case (hdr_cnt_reg)
                        2'd1:    SRAM_write_data <= 16'hBEEF;
                        2'd2:    SRAM_write_data <= {q_reg, width_reg};
                        default: begin
                            SRAM_write_data <= height_reg;
                            state_reg       <= S_DONE;
                        end
                    endcase
                end
                S_LOAD: begin
                    if (ld_cnt_reg != 7'd0 && coef_data != 9'd0) begin
                        last_nz_reg  <= ld_idx;
                        all_zero_reg <= 1'b0;
                    end
                    if (ld_cnt_reg < 7'd63)
                        coef_address <= ld_cnt_reg[5:0] + 6'd1;
                    ld_cnt_reg <= ld_cnt_reg + 7'd1;
                    if (ld_cnt_reg == 7'd64)
                        state_reg <= S_ENCODE;
                end
                S_ENCODE: begin
                    if (cnt_sum[4]) begin
                        SRAM_address    <= next_addr_reg;
                        next_addr_reg   <= next_addr_reg + 18'd1;
                        SRAM_write_data <= appended[31:16];
                        SRAM_we_n       <= 1'b0;
                        acc_reg         <= appended << 16;
                        count_reg       <= {1'b0, cnt_sum[3:0]};
                    end else begin
                        acc_reg   <= appended;
                        count_reg <= cnt_sum;
                    end
                    pos_reg <= pos_next;
                    if (block_end) begin
                        block_done <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                end
                S_FLUSH: begin
                    if (count_reg != 5'd0) begin
                        SRAM_address    <= next_addr_reg;
                        next_addr_reg   <= next_addr_reg + 18'd1;
                        SRAM_write_data <= acc_reg[31:16];
                        SRAM_we_n       <= 1'b0;
                    end
                    acc_reg    <= 32'd0;
                    count_reg  <= 5'd0;
                    flush_done <= 1'b1;
                    state_reg  <= S_DONE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_encoder.sv
// Randomized self-checking bench: a bit-queue reference model predicts every SRAM write
// and the block_start-to-block_done latency of bitstream_encoder.
module tb_bitstream_encoder;

    localparam logic [17:0] OFFS = 18'd76800;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        quantization = 1'b0;
    logic [14:0] width = '0;
    logic [15:0] height = '0;
    logic        block_start = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  coef_address;
    logic [8:0]  coef_data = '0;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic        busy;
    logic        block_done;
    logic        flush_done;

    bitstream_encoder #(.OUTPUT_OFFSET(OFFS)) dut (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .start(start),
        .quantization(quantization), .width(width), .height(height),
        .block_start(block_start), .flush(flush), .coef_address(coef_address),
        .coef_data(coef_data), .SRAM_address(SRAM_address),
        .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n), .busy(busy),
        .block_done(block_done), .flush_done(flush_done)
    );

    always #10 CLOCK_50_I = ~CLOCK_50_I;

    logic [8:0] coef_mem [64];
    always @(posedge CLOCK_50_I) coef_data <= coef_mem[coef_address];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          blk [64];
    bit          mbits[$];
    logic [17:0] maddr = OFFS;
    logic [33:0] exp_q[$];
    logic [33:0] obs_q[$];

    always @(negedge CLOCK_50_I)
        if (SRAM_we_n === 1'b0) obs_q.push_back({SRAM_address, SRAM_write_data});

    task automatic check_val(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_word(input logic [15:0] w);
        exp_q.push_back({maddr, w});
        maddr = maddr + 18'd1;
    endfunction

    function automatic void m_emit(input int val, input int len);
        logic [15:0] w;
        for (int b = len - 1; b >= 0; b--) mbits.push_back(bit'((val >> b) & 1));
        while (mbits.size() >= 16) begin
            for (int k = 0; k < 16; k++) w[15-k] = mbits.pop_front();
            m_word(w);
        end
    endfunction

    // Encodes blk[] by the code table; returns the number of symbols emitted.
    function automatic int m_block();
        int last, i, n, r, v;
        last = -1;
        for (int k = 0; k < 64; k++) if (blk[k] != 0) last = k;
        i = 0;
        n = 0;
        while (i < 64) begin
            n++;
            if (i > last) begin
                m_emit(7, 3);
                break;
            end
            v = blk[i];
            if (v == 0) begin
                r = 0;
                while (i + r < 64 && r < 8 && blk[i+r] == 0) r++;
                m_emit((6 << 3) | (r % 8), 6);
                i += r;
            end else if (v == 1 || v == -1) begin
                r = 0;
                while (i + r < 64 && r < 4 && blk[i+r] == v) r++;
                m_emit((((v == 1) ? 5 : 4) << 2) | (r % 4), 5);
                i += r;
            end else if (v >= -8 && v <= 7) begin
                m_emit(16 | (v & 15), 6);
                i++;
            end else begin
                m_emit(v & 511, 11);
                i++;
            end
        end
        return n;
    endfunction

    function automatic void m_flush();
        logic [15:0] w;
        if (mbits.size() > 0) begin
            w = '0;
            for (int k = 0; k < 16; k++) w[15-k] = (mbits.size() > 0) ? mbits.pop_front() : 1'b0;
            m_word(w);
        end
    endfunction

    task automatic compare_writes(input string tag);
        logic [33:0] e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) check_val({tag, " missing_write"}, 34'd0, e);
            else begin
                o = obs_q.pop_front();
                check_val({tag, " write"}, o, e);
            end
        end
        check_val({tag, " extra_writes"}, 34'(obs_q.size()), 34'd0);
        obs_q.delete();
    endtask

    task automatic run_header(input string tag, input logic q, input int w, input int h, input bit all3);
        int cnt;
        mbits.delete();
        maddr = OFFS;
        m_word(16'hDEAD);
        m_word(16'hBEEF);
        m_word({q, 15'(w)});
        m_word(16'(h));
        @(negedge CLOCK_50_I);
        start = 1'b1; quantization = q; width = 15'(w); height = 16'(h);
        if (all3) begin block_start = 1'b1; flush = 1'b1; end
        cnt = 0;
        do begin
            @(posedge CLOCK_50_I); cnt++;
            @(negedge CLOCK_50_I);
            start = 1'b0; block_start = 1'b0; flush = 1'b0;
            quantization = 1'b0; width = '0; height = '0;
        end while (busy !== 1'b0 && cnt < 20);
        check_val({tag, " hdr_cycles"}, 34'(cnt), 34'd5);
        @(negedge CLOCK_50_I);
        check_val({tag, " idle_after"}, 34'(busy), 34'd0);
        compare_writes(tag);
        $display("header %s q=%0d w=%0d h=%0d cycles=%0d", tag, q, w, h, cnt);
    endtask

    task automatic run_block(input string tag, input bit poke);
        int nsym, cnt;
        bit done;
        nsym = m_block();
        for (int i = 0; i < 64; i++) coef_mem[i] = 9'(blk[i]);
        @(negedge CLOCK_50_I);
        block_start = 1'b1;
        cnt = 0;
        done = 0;
        while (!done && cnt < 400) begin
            @(posedge CLOCK_50_I); cnt++;
            @(negedge CLOCK_50_I);
            block_start = 1'b0;
            start = 1'b0;
            if (cnt == 1) begin
                check_val({tag, " coef_addr0"}, 34'(coef_address), 34'd0);
                check_val({tag, " busy"}, 34'(busy), 34'd1);
            end
            if (poke && cnt == 30) block_start = 1'b1;
            if (poke && cnt == 45) start = 1'b1;
            if (block_done === 1'b1) done = 1;
        end
        check_val({tag, " latency"}, done ? 34'(cnt) : 34'd0, 34'(66 + nsym));
        @(negedge CLOCK_50_I);
        check_val({tag, " done_pulse"}, 34'(block_done), 34'd0);
        check_val({tag, " idle_after"}, 34'(busy), 34'd0);
        compare_writes(tag);
        $display("block %s symbols=%0d latency=%0d residual=%0d", tag, nsym, cnt, mbits.size());
    endtask

    task automatic run_flush(input string tag);
        int cnt;
        bit done;
        m_flush();
        @(negedge CLOCK_50_I);
        flush = 1'b1;
        cnt = 0;
        done = 0;
        while (!done && cnt < 20) begin
            @(posedge CLOCK_50_I); cnt++;
            @(negedge CLOCK_50_I);
            flush = 1'b0;
            if (flush_done === 1'b1) done = 1;
        end
        check_val({tag, " flush_latency"}, done ? 34'(cnt) : 34'd0, 34'd2);
        @(negedge CLOCK_50_I);
        check_val({tag, " idle_after"}, 34'(busy), 34'd0);
        compare_writes(tag);
        $display("flush %s latency=%0d", tag, cnt);
    endtask

    function automatic void clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 0;
    endfunction

    function automatic void gen_block();
        int last, r;
        last = $urandom_range(0, 64);
        for (int i = 0; i < 64; i++) begin
            r = $urandom_range(0, 99);
            if (i >= last || r < 40) blk[i] = 0;
            else if (r < 55) blk[i] = 1;
            else if (r < 65) blk[i] = -1;
            else if (r < 85) blk[i] = int'($urandom_range(0, 15)) - 8;
            else blk[i] = int'($urandom_range(0, 511)) - 256;
        end
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) coef_mem[i] = '0;
        repeat (3) @(negedge CLOCK_50_I);
        check_val("rst SRAM_address", 34'(SRAM_address), 34'(OFFS));
        check_val("rst SRAM_write_data", 34'(SRAM_write_data), 34'd0);
        check_val("rst SRAM_we_n", 34'(SRAM_we_n), 34'd1);
        check_val("rst coef_address", 34'(coef_address), 34'd0);
        check_val("rst busy", 34'(busy), 34'd0);
        check_val("rst block_done", 34'(block_done), 34'd0);
        check_val("rst flush_done", 34'(flush_done), 34'd0);
        resetn = 1'b1;
        @(negedge CLOCK_50_I);

        // start wins over simultaneous block_start and flush
        run_header("hdr0", 1'b1, 320, 240, 1'b1);

        clear_blk();
        blk[0] = 5; blk[4] = 1; blk[5] = 1; blk[6] = -1; blk[7] = -200;
        run_block("plan_mixed", 1'b0);
        run_flush("plan_mixed");

        clear_blk();
        run_block("zero1", 1'b0);
        run_block("zero2", 1'b1);
        run_flush("zero");
        run_flush("empty");

        clear_blk();
        blk[9] = 3;
        run_block("zrun9", 1'b0);
        clear_blk();
        for (int i = 0; i < 5; i++) blk[i] = 1;
        run_block("ones5", 1'b1);
        for (int i = 0; i < 64; i++) blk[i] = (i % 2 == 0) ? -1 : 300;
        run_block("full64", 1'b0);
        run_flush("directed");

        for (int t = 0; t < 25; t++) begin
            gen_block();
            run_block($sformatf("rnd%0d", t), (t % 3) == 0);
            if ($urandom_range(0, 3) == 0) run_flush($sformatf("rnd%0d", t));
            if (t == 12) run_header("hdr1", 1'b0, int'($urandom_range(0, 32767)), int'($urandom_range(0, 65535)), 1'b0);
        end

        // asynchronous reset in the middle of encoding a long block
        for (int i = 0; i < 64; i++) blk[i] = 100 + i;
        for (int i = 0; i < 64; i++) coef_mem[i] = 9'(blk[i]);
        @(negedge CLOCK_50_I);
        block_start = 1'b1;
        @(negedge CLOCK_50_I);
        block_start = 1'b0;
        repeat (90) @(negedge CLOCK_50_I);
        #3 resetn = 1'b0;
        #1;
        check_val("midrst SRAM_we_n", 34'(SRAM_we_n), 34'd1);
        check_val("midrst SRAM_address", 34'(SRAM_address), 34'(OFFS));
        check_val("midrst busy", 34'(busy), 34'd0);
        check_val("midrst coef_address", 34'(coef_address), 34'd0);
        repeat (2) @(negedge CLOCK_50_I);
        resetn = 1'b1;
        obs_q.delete();
        exp_q.delete();
        mbits.delete();
        maddr = OFFS;
        $display("reset mid-encode applied");

        run_header("hdr2", 1'b1, 640, 480, 1'b0);
        for (int t = 0; t < 6; t++) begin
            gen_block();
            run_block($sformatf("post%0d", t), 1'b0);
        end
        run_flush("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitstream_encoder.md
# bitstream_encoder

- Lossless-stage encoder: the transmit-side counterpart of the milestone 3 bitstream decoder.
- Reads one 8x8 block of quantized, scan-ordered 9-bit signed coefficients from a dual-port RAM and compresses it with the variable-length code the decoder parses.
- Packs the code MSB-first into 16-bit words and writes them to SRAM, after a 4-word image header.
- Sits between the quantization stage and the SRAM arbiter.

## Interface
Parameters:
- OUTPUT_OFFSET, 18'd76800, SRAM address of the first header word.

Ports:
- CLOCK_50_I  input  1  50 MHz clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: write header, reset the bit packer; accepted only in S_IDLE.
- quantization  input  1  Q flag written to the header; sampled on start.
- width  input  15  image width; sampled on start.
- height  input  16  image height; sampled on start.
- block_start  input  1  one-cycle pulse: encode one block; accepted only in S_IDLE.
- flush  input  1  one-cycle pulse: write the partial final word; accepted only in S_IDLE.
- coef_address  output  6  coefficient RAM address, scan order.
- coef_data  input  9  signed coefficient; valid 1 cycle after coef_address.
- SRAM_address  output  18  write address.
- SRAM_write_data  output  16  write data.
- SRAM_we_n  output  1  active-low write enable; one word per cycle maximum.
- busy  output  1  high in every state except S_IDLE.
- block_done  output  1  one-cycle pulse at block end.
- flush_done  output  1  one-cycle pulse at flush end.

## Operation
- States and transitions:
  - S_IDLE → S_HEADER on start.
  - S_IDLE → S_LOAD on block_start.
  - S_IDLE → S_FLUSH on flush.
  - Priority when several arrive together: start > block_start > flush.
- S_HEADER: writes 4 words on consecutive cycles at OUTPUT_OFFSET+0..+3: 16'hDEAD, 16'hBEEF, {quantization, width}, height. Next free word address = OUTPUT_OFFSET+4. Bit count cleared.
- S_LOAD: issues coef_address 0..63 on 64 consecutive cycles into a 64x9 local buffer. Tracks last_nz = highest index with a nonzero value; an all-zero flag covers the no-nonzero case.
- S_ENCODE: one symbol per cycle at position i, first matching rule:
  - i > last_nz, or block all zero: emit 111; block ends.
  - v == 0: run r of zeros, capped at 8. Emit 110 + r[2:0] (r=8 → 000).
  - v == 1: run r of ones, capped at 4. Emit 101 + r[1:0] (r=4 → 00).
  - v == -1: same as v == 1 with prefix 100.
  - -8 <= v <= 7: emit 01 + v[3:0].
  - otherwise: emit 00 + v[8:0].
  - Runs are detected combinationally over up to 8 following entries. i advances by the run length. Block also ends when i reaches 64.
- Bit packer:
  - 32-bit accumulator plus 5-bit count; codes are 3-11 bits.
  - When count >= 16 after appending, the top 16 bits are written and count -= 16.
  - Residual bits carry into the next block; blocks are not padded.
  - SRAM_address increments after every write.
- S_FLUSH: if count > 0, write the residual bits left-aligned and zero-padded, then clear count. If count == 0, no write.
- S_DONE: raises block_done or flush_done as appropriate, then returns to S_IDLE.

## Timing
- Reset values:
  - SRAM_address = OUTPUT_OFFSET, SRAM_write_data = 0, SRAM_we_n = 1.
  - coef_address = 0, busy = 0, block_done = 0, flush_done = 0.
  - Bit count 0; state S_IDLE.
- Header: SRAM_we_n low for exactly 4 consecutive cycles, starting the cycle after start.
- Block:
  - coef_address = 0 the cycle after block_start.
  - Encoding starts 1 cycle after the last load data arrives.
  - Encode takes one cycle per symbol. block_done pulses the cycle after the terminating symbol is appended.
  - Latency from block_start to block_done = 66 + symbol count cycles.
- A word write caused by the final symbol occurs no later than the block_done cycle.
- start, block_start or flush arriving while busy is ignored.
- resetn low mid-operation: all outputs return to reset values immediately; partial accumulator contents are discarded.

## Test plan
- start with Q=1, width=320, height=240 → writes at 76800..76803: DEAD, BEEF, 0x8140, 0x00F0; busy returns low after 4 writes.
- Block [5,0,0,0,1,1,-1,-200, rest 0], then flush → words 0x573B at 76804 and 0x449C at 76805; flush writes 0x7000 at 76806.
- All-zero block → no write; count = 3. A second all-zero block → count = 6. flush → 0xFC00.
- Block [9 zeros, 3, rest 0] → codes 110000, 110001, 010011, 111.
- Block [1 x5, rest 0] → codes 10100, 10101, 111.
- block_start while busy → ignored. resetn pulse mid-S_ENCODE → SRAM_we_n = 1, SRAM_address = 76800, busy = 0.
